// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between NUM_REQ load/store requesters.
// Optional bus-wait watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*32-1:0]        req_addr,
  input  logic [NUM_REQ*32-1:0]        req_wdata,
  input  logic [NUM_REQ*4-1:0]         req_strb,
  input  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic [TAG_WIDTH-1:0]         resp_tag,
  output logic                         resp_err,
  output logic [31:0]                  address,
  output logic                         read_enable,
  input  logic                         read_valid,
  input  logic [31:0]                  read_data,
  output logic [31:0]                  write_data,
  output logic                         write_enable,
  output logic [3:0]                   strb,
  input  logic                         write_ready,
  output logic                         busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = IW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("mem_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES > 0");
  end

  logic [1:0]           r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_strb;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0]          r_resp_rdata;
  logic [TAG_WIDTH-1:0] r_resp_tag;
  logic                 r_resp_err;

  logic                 w_grant_valid;
  logic [IW-1:0]        w_grant_idx;
  logic [IW-1:0]        w_next_ptr;
  logic [SW-1:0]        w_scan;
  logic [31:0]          w_g_addr;
  logic [31:0]          w_g_wdata;
  logic [3:0]           w_g_strb;
  logic [TAG_WIDTH-1:0] w_g_tag;
  logic                 w_g_we;
  logic                 w_timeout;

  // Scan starts at the rotating pointer; w_scan wraps by subtraction to avoid a modulo.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = r_ptr;
    w_scan        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + SW'(k);
      if (w_scan >= SW'(NUM_REQ))
        w_scan = w_scan - SW'(NUM_REQ);
      if (!w_grant_valid && req_valid[w_scan[IW-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan[IW-1:0];
      end
    end
  end

  always_comb begin
    w_g_addr  = '0;
    w_g_wdata = '0;
    w_g_strb  = '0;
    w_g_tag   = '0;
    w_g_we    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == w_grant_idx) begin
        w_g_addr  = req_addr[k*32 +: 32];
        w_g_wdata = req_wdata[k*32 +: 32];
        w_g_strb  = req_strb[k*4 +: 4];
        w_g_tag   = req_tag[k*TAG_WIDTH +: TAG_WIDTH];
        w_g_we    = req_we[k];
      end
    end
  end

  assign w_next_ptr = (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wait_cnt;

  assign w_timeout = ((r_state == S_READ) || (r_state == S_WRITE)) &&
                     (r_wait_cnt == CW'(TIMEOUT_CYCLES));

  // Held at zero in IDLE so every READ/WRITE entry starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst)
      r_wait_cnt <= '0;
    else if ((r_state == S_READ) || (r_state == S_WRITE))
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_tag        <= '0;
      r_resp_rdata <= '0;
      r_resp_tag   <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_idx;
            r_addr  <= w_g_addr;
            r_wdata <= w_g_wdata;
            r_strb  <= w_g_strb;
            r_tag   <= w_g_tag;
            r_ptr   <= w_next_ptr;
            r_state <= w_g_we ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (w_timeout) begin
            r_resp_rdata <= 32'hdeadbeef;
            r_resp_tag   <= r_tag;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else if (read_valid) begin
            r_resp_rdata <= read_data;
            r_resp_tag   <= r_tag;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          if (w_timeout) begin
            r_resp_rdata <= 32'hdeadbeef;
            r_resp_tag   <= r_tag;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else if (write_ready) begin
            r_resp_rdata <= '0;
            r_resp_tag   <= r_tag;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are gated by rst so enables and pulses drop in the reset cycle itself.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_grant_valid && !rst)
      req_ready[w_grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if ((r_state == S_RESP) && !rst)
      resp_valid[r_owner] = 1'b1;
  end

  assign read_enable  = (r_state == S_READ)  && !w_timeout && !rst;
  assign write_enable = (r_state == S_WRITE) && !w_timeout && !rst;
  assign address      = r_addr;
  assign write_data   = r_wdata;
  assign strb         = r_strb;
  assign busy         = (r_state != S_IDLE);
  assign resp_rdata   = r_resp_rdata;
  assign resp_tag     = r_resp_tag;
  assign resp_err     = r_resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued at grant time
// and a negedge monitor pops and compares them whenever resp_valid is seen.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_we;
  logic [NR*32-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR*4-1:0]  req_strb;
  logic [NR*TW-1:0] req_tag;
  logic [NR-1:0]   resp_valid;
  logic [31:0]     resp_rdata;
  logic [TW-1:0]   resp_tag;
  logic            resp_err;
  logic [31:0]     address;
  logic            read_enable;
  logic            read_valid;
  logic [31:0]     read_data;
  logic [31:0]     write_data;
  logic            write_enable;
  logic [3:0]      strb;
  logic            write_ready;
  logic            busy;

  mem_port_arbiter #(
    .NUM_REQ(NR),
    .TAG_WIDTH(TW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag), .resp_err(resp_err),
    .address(address), .read_enable(read_enable), .read_valid(read_valid), .read_data(read_data),
    .write_data(write_data), .write_enable(write_enable), .strb(strb),
    .write_ready(write_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] oh;
    logic [31:0]   rdata;
    logic [TW-1:0] tag;
    logic          err;
    int unsigned   at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(mon_e.oh));
        check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
        check("resp_tag",   64'(resp_tag),   64'(mon_e.tag));
        check("resp_err",   64'(resp_err),   64'(mon_e.err));
        check("resp_cycle", 64'(cyc),        64'(mon_e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] st, input logic [TW-1:0] tag);
    req_we[idx]             = we;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_strb[idx*4 +: 4]    = st;
    req_tag[idx*TW +: TW]   = tag;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({req_ready, resp_valid, resp_tag, resp_err, read_enable,
                                write_enable, strb, busy}), 64'd0);
    check({name, "_data"}, {resp_rdata, address}, 64'd0);
    check({name, "_wdata"}, 64'(write_data), 64'd0);
  endtask

  int unsigned t0;
  logic [NR-1:0] exp_rdy;

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_tag = '0; read_valid = 1'b0; read_data = '0; write_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Load from requester 0, memory answers one cycle after read_enable.
    set_req(0, 1'b0, 32'h80001000, 32'h0, 4'hf, 4'd3);
    req_valid = 2'b01;
    t0 = cyc;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'(2'b01));
    sb.push_back('{2'b01, 32'h12345678, 4'd3, 1'b0, t0 + 3});
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_rd_en_1", 64'({read_enable, write_enable, req_ready}), 64'(4'b1000));
    check("t1_addr", 64'(address), 64'h80001000);
    tick();
    read_valid = 1'b1; read_data = 32'h12345678;
    @(negedge clk);
    check("t1_rd_en_2", 64'(read_enable), 64'd1);
    tick();
    read_valid = 1'b0; read_data = '0;
    @(negedge clk);
    check("t1_resp_state", 64'({busy, read_enable, req_ready}), 64'(4'b1000));
    tick();

    // Two loads held continuously with read_valid tied high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'h80000100, 32'h0, 4'hf, 4'd5);
    set_req(1, 1'b0, 32'h80000200, 32'h0, 4'hf, 4'd9);
    req_valid = 2'b11; read_valid = 1'b1; read_data = 32'h0badf00d;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_rdy = '0;
      if (i % 3 == 0) exp_rdy = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      check("t2_ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy == 2'b01) sb.push_back('{2'b01, 32'h0badf00d, 4'd5, 1'b0, t0 + i + 2});
      if (exp_rdy == 2'b10) sb.push_back('{2'b10, 32'h0badf00d, 4'd9, 1'b0, t0 + i + 2});
      tick();
    end
    req_valid = '0; read_valid = 1'b0; read_data = '0;
    tick();

    // Store from requester 1 with write_ready four cycles late.
    set_req(1, 1'b1, 32'h80002004, 32'hcafef00d, 4'b0011, 4'd7);
    req_valid = 2'b10;
    t0 = cyc;
    @(negedge clk);
    check("t3_ready", 64'(req_ready), 64'(2'b10));
    sb.push_back('{2'b10, 32'h0, 4'd7, 1'b0, t0 + 6});
    tick();
    req_valid = '0;
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) write_ready = 1'b1;
      @(negedge clk);
      check("t3_bus_ctrl", 64'({write_enable, read_enable, strb}), 64'(6'b10_0011));
      check("t3_bus_data", {address, write_data}, {32'h80002004, 32'hcafef00d});
      tick();
    end
    write_ready = 1'b0;
    @(negedge clk);
    tick();

    // Reset while a load from requester 0 waits in READ.
    set_req(0, 1'b0, 32'h80003000, 32'h0, 4'hf, 4'd2);
    req_valid = 2'b01;
    @(negedge clk);
    check("t4_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t4_rd_en", 64'(read_enable), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t4_rd_en_in_rst", 64'({read_enable, write_enable}), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t4_after_rst");
    tick();
    set_req(1, 1'b0, 32'h80003100, 32'h0, 4'hf, 4'd4);
    req_valid = 2'b11;
    t0 = cyc;
    @(negedge clk);
    check("t4_first_grant", 64'(req_ready), 64'(2'b01));
    sb.push_back('{2'b01, 32'h600df00d, 4'd2, 1'b0, t0 + 2});
    tick();
    req_valid = '0; read_valid = 1'b1; read_data = 32'h600df00d;
    tick();
    read_valid = 1'b0; read_data = '0;
    @(negedge clk);
    tick();

    // Spurious read_valid in IDLE, then a load from requester 1.
    read_valid = 1'b1; read_data = 32'hffffffff;
    @(negedge clk);
    check("t5_idle_busy", 64'({busy, read_enable}), 64'd0);
    tick();
    read_valid = 1'b0; read_data = '0;
    set_req(1, 1'b0, 32'h80004000, 32'h0, 4'hf, 4'he);
    req_valid = 2'b10;
    t0 = cyc;
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'(2'b10));
    sb.push_back('{2'b10, 32'h55aa33cc, 4'he, 1'b0, t0 + 4});
    tick();
    req_valid = '0;
    tick();
    tick();
    read_valid = 1'b1; read_data = 32'h55aa33cc;
    @(negedge clk);
    check("t5_rd_en", 64'(read_enable), 64'd1);
    tick();
    read_valid = 1'b0; read_data = '0;
    @(negedge clk);
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: read_valid never arrives.
    set_req(0, 1'b0, 32'h80005000, 32'h0, 4'hf, 4'd1);
    req_valid = 2'b01;
    t0 = cyc;
    @(negedge clk);
    check("t6_ready", 64'(req_ready), 64'(2'b01));
    sb.push_back('{2'b01, 32'hdeadbeef, 4'd1, 1'b1, t0 + 10});
    tick();
    req_valid = '0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check("t6_rd_en", 64'(read_enable), (j <= 8) ? 64'd1 : 64'd0);
      tick();
    end
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);
    tick();
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single data-memory port (address/read_enable/read_valid/write_enable/strb/write_ready) between NUM_REQ load/store requesters, one per dispatch bank.
- Round-robin arbitration; one transaction outstanding at a time.
- FSM drives the bus handshake and returns a tagged one-cycle response to the originating requester.
- Sits between the per-bank load/store execute slots and the core's external memory ports.

Parameters:
- NUM_REQ, 2, number of requesters (equals DISPATCH_WIDTH); at least 2.
- TAG_WIDTH, 4, width of the opaque requester tag (ROB address) echoed in the response.
- TIMEOUT_CYCLES, 255, bus-wait watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_we  input  NUM_REQ  1=store, 0=load
- req_addr  input  NUM_REQ*32  packed addresses; requester i at bits [32i+31:32i]
- req_wdata  input  NUM_REQ*32  packed store data
- req_strb  input  NUM_REQ*4  packed byte strobes
- req_tag  input  NUM_REQ*TAG_WIDTH  packed tags
- resp_valid  output  NUM_REQ  one-hot response pulse to the owning requester
- resp_rdata  output  32  load data (0 for stores)
- resp_tag  output  TAG_WIDTH  tag of the completed request
- resp_err  output  1  transaction aborted by watchdog
- address  output  32  memory address
- read_enable  output  1  memory read request
- read_valid  input  1  memory read data valid
- read_data  input  32  memory read data
- write_data  output  32  memory write data
- write_enable  output  1  memory write request
- strb  output  4  memory byte strobes
- write_ready  input  1  memory write accepted
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values:
  - state = IDLE; rr pointer = 0 (requester 0 highest priority).
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_tag, resp_err, address, read_enable, write_data, write_enable, strb, busy.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Grant the first asserted req_valid, scanning from the rr pointer upward with wrap-around.
  - req_ready[grant] = 1 combinationally in the same cycle. req_ready is 0 in every other state.
  - On a grant, latch addr, wdata, strb, tag, we and the requester index.
  - Next state is WRITE if we = 1, otherwise READ.
  - rr pointer becomes (grant+1) mod NUM_REQ.
  - With no req_valid: stay in IDLE; pointer unchanged.
- READ:
  - read_enable = 1; address/strb come from the latched values.
  - When read_valid = 1: capture read_data into resp_rdata, then go to RESP.
- WRITE:
  - write_enable = 1; address, write_data and strb come from the latched values.
  - When write_ready = 1: resp_rdata = 0, then go to RESP.
- RESP:
  - resp_valid[owner] = 1 for exactly one cycle; resp_tag holds the latched tag.
  - Next state is IDLE. No new grant is made in RESP, so the earliest next accept is the following cycle.
- Latency: accept at cycle T, bus request from T+1; with a same-cycle memory reply, resp_valid at T+2.
- Minimum spacing between accepts: 3 cycles.
- Bus outputs are held stable while waiting, for unbounded time.
- read_valid or write_ready outside READ/WRITE respectively are ignored.
- Requesters must hold req_valid and payload until req_ready; dropping req_valid before grant is legal.
- resp_rdata/resp_tag hold their last values outside RESP; consumers qualify them with resp_valid.
- rst mid-transaction: return to IDLE immediately; drop the in-flight request with no response; bus enables deassert in the reset cycle.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to READ/WRITE and increments every waiting cycle.
  - When the count reaches TIMEOUT_CYCLES without a handshake: go to RESP with resp_err = 1 and resp_rdata = 32'hdeadbeef.
  - The bus enable drops that cycle.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; resp_err tied 0; waits forever.

Test Plan:
- req_valid=2'b01, load addr 0x80001000, tag 3; memory gives read_valid with data 0x12345678 one cycle after read_enable.
  -> req_ready[0] at T; read_enable T+1..T+2; resp_valid=2'b01, rdata 0x12345678, tag 3 at T+3.
- req_valid=2'b11 held continuously, both loads, read_valid tied 1.
  -> grants alternate 0,1,0,1; accepts every 3 cycles; no starvation.
- Store from requester 1, wdata 0xcafef00d, strb 4'b0011; write_ready delayed 4 cycles.
  -> write_enable/address/write_data/strb stable 5 cycles; resp_valid=2'b10, rdata 0.
- rst asserted while in READ.
  -> next cycle all outputs 0, state IDLE, no resp_valid; a subsequent request from requester 0 is granted first.
- read_valid pulsed while IDLE, then a load issued.
  -> spurious pulse ignored; load completes normally with the correct data.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, read_valid never asserted.
  -> resp_valid with resp_err=1, rdata 0xdeadbeef after 8 wait cycles; busy returns to 0.
